// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, parallel load, logical shifts, rotates,
// synchronous clear and invert, with combinational status taps derived from q.
module univ_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             sout_l,
    output logic             sout_r,
    output logic             zero
);

    localparam logic [2:0] MODE_HOLD   = 3'b000;
    localparam logic [2:0] MODE_LOAD   = 3'b001;
    localparam logic [2:0] MODE_SHL    = 3'b010;
    localparam logic [2:0] MODE_SHR    = 3'b011;
    localparam logic [2:0] MODE_ROL    = 3'b100;
    localparam logic [2:0] MODE_ROR    = 3'b101;
    localparam logic [2:0] MODE_CLEAR  = 3'b110;
    localparam logic [2:0] MODE_INVERT = 3'b111;

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;

    // Next-state selection; an unknown mode falls back to holding the value.
    always_comb begin
        shift_d = shift_q;
        if (en) begin
            case (mode)
                MODE_HOLD:   shift_d = shift_q;
                MODE_LOAD:   shift_d = d;
                MODE_SHL:    shift_d = {shift_q[WIDTH-2:0], sin_l};
                MODE_SHR:    shift_d = {sin_r, shift_q[WIDTH-1:1]};
                MODE_ROL:    shift_d = {shift_q[WIDTH-2:0], shift_q[WIDTH-1]};
                MODE_ROR:    shift_d = {shift_q[0], shift_q[WIDTH-1:1]};
                MODE_CLEAR:  shift_d = RESET_VAL;
                MODE_INVERT: shift_d = ~shift_q;
                default:     shift_d = shift_q;
            endcase
        end else begin
            shift_d = shift_q;
        end
    end

    // The only state element; async reset forces RESET_VAL between edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= RESET_VAL;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign q      = shift_q;
    assign qb     = ~shift_q;
    assign sout_l = shift_q[WIDTH-1];
    assign sout_r = shift_q[0];
    assign zero   = (shift_q == {WIDTH{1'b0}});

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8: register width in bits; legal range 2..64.
REQ-002 Parameter RESET_VAL, default 0: WIDTH-bit value loaded into q on reset and by the CLEAR mode.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge only.
REQ-004 Port reset, input, 1: asynchronous, active-low reset; reset=0 SHALL force state immediately, independent of clk.
REQ-005 Port en, input, 1: operation enable; en=0 SHALL hold q regardless of mode.
REQ-006 Port mode, input, 3: operation select; encoding per REQ-013.
REQ-007 Port d, input, WIDTH: parallel load data.
REQ-008 Port sin_l, input, 1: serial input into bit 0 on shift-left.
REQ-009 Port sin_r, input, 1: serial input into bit WIDTH-1 on shift-right.
REQ-010 Port q, output, WIDTH: registered contents.
REQ-011 Port qb, output, WIDTH: bitwise complement of q, combinational from q.
REQ-012 Ports sout_l, sout_r, zero, output, 1 each: sout_l=q[WIDTH-1], sout_r=q[0], zero=1 iff q==0; all combinational from q.

Function
REQ-013 On each rising clk with reset=1 and en=1, next q SHALL be set by mode as follows:
  - 000 HOLD: q unchanged.
  - 001 LOAD: q<=d.
  - 010 SHL: q<={q[WIDTH-2:0],sin_l}.
  - 011 SHR: q<={sin_r,q[WIDTH-1:1]}.
  - 100 ROL: q<={q[WIDTH-2:0],q[WIDTH-1]}.
  - 101 ROR: q<={q[0],q[WIDTH-1:1]}.
  - 110 CLEAR: q<=RESET_VAL (synchronous).
  - 111 INVERT: q<=~q.
REQ-014 Every operation SHALL take effect in exactly one cycle: the new q is visible after the same rising edge that sampled mode, d, sin_l and sin_r.
REQ-015 sin_l SHALL be ignored in every mode except SHL, and sin_r SHALL be ignored in every mode except SHR.
REQ-016 Shifts SHALL discard the bit shifted out; that bit SHALL remain observable on sout_l/sout_r only before the edge.
REQ-017 Rotates SHALL preserve the population count of q.
REQ-018 Applying ROL or ROR WIDTH consecutive times SHALL return q to its original value.
REQ-019 The register SHALL contain no internal state besides q; no latency or pipeline stage SHALL exist between q and qb, sout_l, sout_r or zero.
REQ-020 An X or Z on mode SHALL NOT be required to produce defined behaviour; the bench SHALL drive only defined values.
REQ-021 While en=0, mode, d, sin_l and sin_r SHALL have no effect.

Reset
REQ-022 While reset=0: q=RESET_VAL, qb=~RESET_VAL, sout_l=RESET_VAL[WIDTH-1], sout_r=RESET_VAL[0], zero=(RESET_VAL==0).
REQ-023 Reset assertion SHALL take effect asynchronously, including mid-operation between clock edges.
REQ-024 Reset SHALL override en and mode.
REQ-025 On the first rising clk after reset deassertion with en=1, the selected operation SHALL execute normally on RESET_VAL.
REQ-026 If reset deasserts coincident with a rising clk, that edge SHALL NOT update q.

Verification (WIDTH=8, RESET_VAL=0 unless stated)
REQ-027 Reset then LOAD d=8'hA5 -> next cycle q=8'hA5, qb=8'h5A, zero=0, sout_l=1, sout_r=1.
REQ-028 From q=8'h81: SHL with sin_l=0 -> 8'h02; then SHR with sin_r=1 -> 8'h81; then ROL -> 8'h03; then ROR -> 8'h81.
REQ-029 From q=8'h96: ROL 8 times -> q=8'h96 and popcount 4 after every step; INVERT -> 8'h69; CLEAR -> 8'h00 with zero=1.
REQ-030 With q=8'h3C: en=0, mode=LOAD, d=8'hFF for 5 cycles -> q remains 8'h3C.
REQ-031 During a SHL burst, pulse reset=0 between edges -> q=8'h00 immediately; release coincident with clk -> q stays 8'h00 on that edge; next SHL with sin_l=1 -> 8'h01.
REQ-032 With RESET_VAL=8'hF0: assert reset -> q=8'hF0, zero=0; LOAD 8'h00 -> zero=1; CLEAR -> q=8'hF0.
